// File: rtl/pcileech_sysctl_pkg.sv
// Purpose: shared types and default constants for the system control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sysctl_state_t state encoding, default cycle counts and blink bits.
package pcileech_sysctl_pkg;

  typedef enum logic [1:0] {
    S_POR     = 2'd0,  // power-on / post-release reset hold
    S_RUN     = 2'd1,  // normal operation, design out of reset
    S_BTN_RST = 2'd2,  // sw2 held: design held in reset, counting hold time
    S_RELOAD  = 2'd3   // sw2 held long enough: config reload requested
  } sysctl_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;    // 10 ms at 100 MHz
  localparam int DEF_RST_HOLD_CYCLES = 64;
  localparam int DEF_RELOAD_CYCLES   = 500000000;  // 5 s at 100 MHz
  localparam int DEF_BLINK_BIT       = 24;
  localparam int DEF_BLINK_END_BIT   = 27;

endpackage

// File: rtl/pcileech_debounce.sv
// Purpose: 2-FF synchronizer plus debouncer for one active-low push button.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles from pin edge to dout change.
// Backpressure: none, free-running.
// Ports: clk, rst_n (sync, active-low), din_n (async button, low = pressed),
//        dout (debounced pressed level, 1 = pressed).
module pcileech_debounce
  import pcileech_sysctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_n,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          pressed_sync;
  logic [CW-1:0] cnt;

  assign pressed_sync = ~sync_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Synchronizer idles at the released level so reset never looks like a press.
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      cnt    <= '0;
      dout   <= 1'b0;
    end else begin
      sync_a <= din_n;
      sync_b <= sync_a;
      if (pressed_sync != dout) begin
        // The level must disagree for DEBOUNCE_CYCLES consecutive cycles;
        // any agreeing cycle in between restarts the count.
        if (cnt == CNT_LAST) begin
          dout <= ~dout;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pcileech_sysctl.sv
// Purpose: system control: button debounce, design reset sequencing, config reload, tick counter, power-on blink.
// Latency: sw2_db to rst 1 cycle; sw2_db release to rst low 1+RST_HOLD_CYCLES; led 1 cycle behind tickcount64/sw1_db.
// Backpressure: none, all outputs are free-running levels.
// Ports: clk, rst_n (sync, active-low), user_sw1_n/user_sw2_n (async buttons, active-low),
//        rst, rst_cfg_reload, tickcount64, led_pwronblink, sw1_db, sw2_db.
module pcileech_sysctl
  import pcileech_sysctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int RELOAD_CYCLES   = DEF_RELOAD_CYCLES,
  parameter int BLINK_BIT       = DEF_BLINK_BIT,
  parameter int BLINK_END_BIT   = DEF_BLINK_END_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        user_sw1_n,
  input  logic        user_sw2_n,
  output logic        rst,
  output logic        rst_cfg_reload,
  output logic [63:0] tickcount64,
  output logic        led_pwronblink,
  output logic        sw1_db,
  output logic        sw2_db
);

  localparam int POR_W  = $clog2(RST_HOLD_CYCLES + 1);
  localparam int HOLD_W = $clog2(RELOAD_CYCLES + 1);

  localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(RST_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RELOAD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RELOAD_CYCLES);

  sysctl_state_t     state;
  logic [POR_W-1:0]  por_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              blink_on;

  pcileech_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_sw1 (
    .clk  (clk),
    .rst_n(rst_n),
    .din_n(user_sw1_n),
    .dout (sw1_db)
  );

  pcileech_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_sw2 (
    .clk  (clk),
    .rst_n(rst_n),
    .din_n(user_sw2_n),
    .dout (sw2_db)
  );

  // Sequencer. Outputs are registered from the state being entered, so rst and
  // rst_cfg_reload change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_POR;
      por_cnt        <= '0;
      hold_cnt       <= '0;
      rst            <= 1'b1;
      rst_cfg_reload <= 1'b0;
      tickcount64    <= '0;
    end else begin
      rst            <= 1'b1;
      rst_cfg_reload <= 1'b0;
      tickcount64    <= tickcount64 + 64'd1;
      case (state)
        S_POR: begin
          if (sw2_db) begin
            // Button wins over the power-on hold expiring in the same cycle.
            state       <= S_BTN_RST;
            hold_cnt    <= '0;
            tickcount64 <= '0;
          end else if (por_cnt == POR_LAST) begin
            state <= S_RUN;
            rst   <= 1'b0;
          end else begin
            por_cnt <= por_cnt + POR_W'(1);
          end
        end
        S_RUN: begin
          if (sw2_db) begin
            state       <= S_BTN_RST;
            hold_cnt    <= '0;
            tickcount64 <= '0;
          end else begin
            rst <= 1'b0;
          end
        end
        S_BTN_RST: begin
          // Tick counter is parked at 0 here and restarts from 0 on release.
          tickcount64 <= '0;
          if (!sw2_db) begin
            state   <= S_POR;
            por_cnt <= '0;
          end else begin
            if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if (hold_cnt == HOLD_LAST) begin
              state          <= S_RELOAD;
              rst_cfg_reload <= 1'b1;
            end
          end
        end
        S_RELOAD: begin
          tickcount64 <= '0;
          if (!sw2_db) begin
            // Reload request drops on the exit edge; rst stays high into S_POR.
            state   <= S_POR;
            por_cnt <= '0;
          end else begin
            rst_cfg_reload <= 1'b1;
          end
        end
        default: begin
          state   <= S_POR;
          por_cnt <= '0;
        end
      endcase
    end
  end

  // Blink only while the tick counter is still small after (re)start.
  assign blink_on = tickcount64[BLINK_BIT] & ~(|tickcount64[63:BLINK_END_BIT]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_pwronblink <= 1'b0;
    end else begin
      led_pwronblink <= sw1_db ^ blink_on;
    end
  end

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Purpose: randomized self-checking bench for pcileech_sysctl against a timing-rule model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pcileech_sysctl;

  localparam int DEB   = 4;
  localparam int HOLD  = 64;
  localparam int RLD   = 100;
  localparam int BBIT  = 3;
  localparam int BEND  = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        user_sw1_n;
  logic        user_sw2_n;
  logic        rst;
  logic        rst_cfg_reload;
  logic [63:0] tickcount64;
  logic        led_pwronblink;
  logic        sw1_db;
  logic        sw2_db;

  int n_chk = 0;
  int n_err = 0;

  // Current button pin levels (active-low).
  logic b1 = 1'b1;
  logic b2 = 1'b1;

  pcileech_sysctl #(
    .DEBOUNCE_CYCLES(DEB),
    .RST_HOLD_CYCLES(HOLD),
    .RELOAD_CYCLES  (RLD),
    .BLINK_BIT      (BBIT),
    .BLINK_END_BIT  (BEND)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .user_sw1_n    (user_sw1_n),
    .user_sw2_n    (user_sw2_n),
    .rst           (rst),
    .rst_cfg_reload(rst_cfg_reload),
    .tickcount64   (tickcount64),
    .led_pwronblink(led_pwronblink),
    .sw1_db        (sw1_db),
    .sw2_db        (sw2_db)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pin delay lines (two sampling edges), debounced levels with disagreement run lengths.
  logic m1_new, m1_old, m2_new, m2_old;
  logic m_db1, m_db2;
  int   m_run1, m_run2;
  // System view: either "held" (sw2 was pressed at the last edge) or "up"
  // for m_up edges since reset / since release.
  bit              m_hold;
  longint unsigned m_up;
  longint unsigned m_held;
  logic [63:0]     m_tick;
  logic            m_led;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic deb_step(input logic synced_n, inout logic db, inout int run);
    if (!synced_n != db) begin
      run++;
      if (run == DEB) begin
        db  = !db;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_edge(input logic n_rst, input logic p1, input logic p2);
    logic new_led;
    if (!n_rst) begin
      m1_new = 1'b1; m1_old = 1'b1; m2_new = 1'b1; m2_old = 1'b1;
      m_db1 = 1'b0; m_db2 = 1'b0; m_run1 = 0; m_run2 = 0;
      m_hold = 1'b0; m_up = 0; m_held = 0; m_tick = '0; m_led = 1'b0;
    end else begin
      new_led = m_db1 ^ (m_tick[BBIT] && ((m_tick >> BEND) == 64'd0));
      if (m_db2) begin
        if (!m_hold) m_held = 0;
        m_hold = 1'b1;
        m_held++;
      end else begin
        if (m_hold) m_up = 0;
        else        m_up++;
        m_hold = 1'b0;
      end
      m_tick = m_hold ? 64'd0 : m_up;
      m_led  = new_led;
      deb_step(m1_old, m_db1, m_run1);
      deb_step(m2_old, m_db2, m_run2);
      m1_old = m1_new; m1_new = p1;
      m2_old = m2_new; m2_new = p2;
    end
  endtask

  // One clock: drive, model the edge, compare on the falling edge.
  task automatic cyc(input logic n_rst);
    rst_n      = n_rst;
    user_sw1_n = b1;
    user_sw2_n = b2;
    @(posedge clk);
    model_edge(n_rst, b1, b2);
    @(negedge clk);
    chk("rst",    {63'd0, rst},            {63'd0, (m_hold || (m_up < HOLD))});
    chk("reload", {63'd0, rst_cfg_reload}, {63'd0, (m_hold && (m_held > RLD))});
    chk("tick",   tickcount64,             m_tick);
    chk("led",    {63'd0, led_pwronblink}, {63'd0, m_led});
    chk("sw1_db", {63'd0, sw1_db},         {63'd0, m_db1});
    chk("sw2_db", {63'd0, sw2_db},         {63'd0, m_db2});
  endtask

  // Run cycles with sw1 randomly toggling, giving both bounces and real presses.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 39) == 0) b1 = ~b1;
      cyc(1'b1);
    end
  endtask

  task automatic rst_pulse(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0);
  endtask

  initial begin
    int sel;
    rst_n = 1'b0;
    user_sw1_n = 1'b1;
    user_sw2_n = 1'b1;
    rst_pulse(5);
    idle(120);

    for (int i = 0; i < 40; i++) begin
      sel = (i < 5) ? i : int'($urandom_range(0, 4));
      case (sel)
        0: begin  // bounce shorter than the debounce window
          b2 = 1'b0; idle($urandom_range(1, 3));
          b2 = 1'b1; idle($urandom_range(10, 40));
        end
        1: begin  // short press: reset without reload
          b2 = 1'b0; idle($urandom_range(20, 60));
          b2 = 1'b1; idle($urandom_range(70, 120));
        end
        2: begin  // long press: reaches reload
          b2 = 1'b0; idle($urandom_range(150, 220));
          b2 = 1'b1; idle($urandom_range(70, 100));
        end
        3: begin  // external reset while reload is asserted
          b2 = 1'b0; idle($urandom_range(130, 160));
          rst_pulse($urandom_range(1, 3));
          b2 = 1'b1; idle(80);
        end
        default: begin
          rst_pulse($urandom_range(1, 3));
          idle($urandom_range(20, 100));
        end
      endcase
    end

    // Final directed pass: reset lands squarely inside S_RELOAD.
    b2 = 1'b0; idle(2 + DEB + RLD + 10);
    rst_pulse(1);
    b2 = 1'b1; idle(90);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
